// File: rtl/vote_pkg.sv
// Shared types and constants for the vote frame collector and its timeout counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, frame length, population-count width and a popcount helper.
package vote_pkg;

    localparam int STATE_W   = 2;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Zero-extended sum of the frame bits; CNT_W is wide enough for FRAME_LEN ones.
    function automatic logic [CNT_W-1:0] popcount(input logic [FRAME_LEN-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            s = s + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return s;
    endfunction

endpackage

// File: rtl/vote_timeout_ctr.sv
// Counts idle cycles between accepted bits of a frame; flags when the limit is hit.
// Latency: expired is combinational and fires in the cycle whose edge brings the count to TIMEOUT.
// Backpressure: none; the owning FSM drives clear/en every cycle.
// Ports: clk, rst_n (sync, active-low), clear (zero the count), en (count one idle cycle), expired.
module vote_timeout_ctr #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W:0] LIMIT = (TO_W+1)'(TIMEOUT);

    logic [TO_W-1:0] count_q, count_d;
    logic [TO_W:0]   count_inc;

    // One extra bit so the compare is exact even when TIMEOUT is the max count.
    assign count_inc = {1'b0, count_q} + (TO_W+1)'(1);

    // Fires on the idle cycle whose edge makes the count equal TIMEOUT, so the
    // abort lands on that same edge.
    assign expired = en && (count_inc == LIMIT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_inc[TO_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vote_frame_collector.sv
// Serial-to-parallel collector: gathers a 4-bit vote frame, presents a..d plus ones_cnt.
// Latency: outputs valid the cycle after the edge that accepts the 4th bit.
// Backpressure: out_valid holds until out_ready; stalled/interrupted frames abort with frame_err.
// Ports: start/bit_valid/bit_in in, out_ready in; a..d, ones_cnt, out_valid, busy, frame_err out.
module vote_frame_collector
    import vote_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             out_ready,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic [CNT_W-1:0] ones_cnt,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err
);

    state_t                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shadow_q, shadow_d;
    logic [1:0]             idx_q, idx_d;
    logic [FRAME_LEN-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]       ones_q, ones_d;
    logic                   out_valid_q, out_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic                   to_en;
    logic                   to_clear;
    logic                   to_expired;
    logic [FRAME_LEN-1:0]   shadow_next;

    // Count only genuinely idle COLLECT cycles; any bit, restart or other state zeroes it.
    assign to_en    = (state_q == COLLECT) && !start && !bit_valid;
    assign to_clear = !to_en;

    vote_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (to_clear),
        .en      (to_en),
        .expired (to_expired)
    );

    // First bit of the frame ends up in the MSB, which maps to a.
    assign shadow_next = {shadow_q[FRAME_LEN-2:0], bit_in};

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        ones_d      = ones_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = COLLECT;
                    idx_d    = '0;
                    shadow_d = '0;
                end
            end
            COLLECT: begin
                if (start) begin
                    // Restart wins over a bit in the same cycle; that bit is dropped.
                    frame_err_d = 1'b1;
                    idx_d       = '0;
                    shadow_d    = '0;
                end else if (bit_valid) begin
                    shadow_d = shadow_next;
                    idx_d    = idx_q + 2'd1;
                    if (idx_q == 2'(FRAME_LEN-1)) begin
                        frame_d     = shadow_next;
                        ones_d      = popcount(shadow_next);
                        out_valid_d = 1'b1;
                        idx_d       = '0;
                        state_d     = HOLD;
                    end
                end else if (to_expired) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        state_d  = COLLECT;
                        idx_d    = '0;
                        shadow_d = '0;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            idx_q       <= '0;
            frame_q     <= '0;
            ones_q      <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            ones_q      <= ones_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign a         = frame_q[3];
    assign b         = frame_q[2];
    assign c         = frame_q[1];
    assign d         = frame_q[0];
    assign ones_cnt  = ones_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == COLLECT);
    assign frame_err = frame_err_q;

endmodule
